lc4_issue_ctrl: RTL and testbench

In-order issue controller for the ECC-extended LC4 pipeline. It sits between decode and execute. Each cycle it takes one decoded instruction, holds it back on register hazards or writeback-port conflicts, and tracks in-flight destination registers in a 32-entry scoreboard. It also schedules the single register-file write port across short and long (ECC) latencies and drains the pipeline around control instructions.

---
 rtl/lc4_issue_ctrl.sv | 115 +++++++++++
 tb/tb_lc4_issue_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lc4_issue_ctrl.sv
// In-order issue controller for the ECC-extended LC4 pipeline: scoreboard hazard
// checks, single write-port scheduling across short/long latencies, control drain.
module lc4_issue_ctrl #(
    parameter int EX_LAT  = 2,
    parameter int ECC_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       d_valid,
    input  logic [4:0] d_r1sel,
    input  logic       d_r1re,
    input  logic [4:0] d_r2sel,
    input  logic       d_r2re,
    input  logic [4:0] d_wsel,
    input  logic       d_regfile_we,
    input  logic       d_long,
    input  logic       d_is_control,
    output logic       d_ready,
    output logic       x_issue,
    output logic       flush_fetch,
    output logic       wb_valid,
    output logic [4:0] wb_sel,
    output logic       wb_we,
    output logic       busy
);

    // Handshake: an instruction transfers in any cycle where d_valid and d_ready
    // are both high; d_ready never depends on x_issue and nothing is latched.

    typedef struct packed {
        logic       v;
        logic [4:0] sel;
        logic       we;
    } slot_t;

    slot_t       slot_q [1:ECC_LAT];
    slot_t       slot_d [1:ECC_LAT];
    logic [31:0] pending_q;
    logic [31:0] pending_d;
    logic        flush_q;

    logic any_slot;
    logic raw_hazard;
    logic waw_hazard;
    logic port_conflict;
    logic control_drain;

    always_comb begin
        any_slot = 1'b0;
        for (int k = 1; k <= ECC_LAT; k++) begin
            any_slot = any_slot | slot_q[k].v;
        end
    end

    assign busy = (|pending_q) | any_slot;

    assign raw_hazard    = (d_r1re & pending_q[d_r1sel]) | (d_r2re & pending_q[d_r2sel]);
    assign waw_hazard    = d_regfile_we & pending_q[d_wsel];
    // A short op landing in slot EX_LAT would collide with whatever shifts down
    // from slot EX_LAT+1; long ops enter the top slot and can never collide.
    assign port_conflict = ~d_long & slot_q[EX_LAT+1].v;
    assign control_drain = d_is_control & busy;

    // rst_n gating keeps d_ready low for the whole time reset is asserted.
    assign d_ready = rst_n & d_valid & ~raw_hazard & ~waw_hazard & ~port_conflict
                     & ~control_drain & ~flush_q;
    assign x_issue = d_valid & d_ready;

    assign flush_fetch = flush_q;
    assign wb_valid    = slot_q[1].v;
    assign wb_sel      = slot_q[1].sel;
    assign wb_we       = slot_q[1].we;

    always_comb begin
        for (int k = 1; k < ECC_LAT; k++) begin
            slot_d[k] = slot_q[k+1];
        end
        slot_d[ECC_LAT] = '0;
        if (x_issue) begin
            if (d_long) begin
                slot_d[ECC_LAT] = '{v: 1'b1, sel: d_wsel, we: d_regfile_we};
            end else begin
                slot_d[EX_LAT] = '{v: 1'b1, sel: d_wsel, we: d_regfile_we};
            end
        end
    end

    // Clear is applied before set so a same-index collision resolves to set.
    always_comb begin
        pending_d = pending_q;
        if (slot_q[1].v && slot_q[1].we) begin
            pending_d[slot_q[1].sel] = 1'b0;
        end
        if (x_issue && d_regfile_we) begin
            pending_d[d_wsel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= ECC_LAT; k++) begin
                slot_q[k] <= '0;
            end
            pending_q <= '0;
            flush_q   <= 1'b0;
        end else begin
            for (int k = 1; k <= ECC_LAT; k++) begin
                slot_q[k] <= slot_d[k];
            end
            pending_q <= pending_d;
            flush_q   <= x_issue & d_is_control;
        end
    end

endmodule

// File: tb/tb_lc4_issue_ctrl.sv
// Bench for lc4_issue_ctrl: directed scenarios plus random traffic, all checked
// against an in-flight-operation list model driven by issue/retire times.
module tb_lc4_issue_ctrl;

    localparam int EX_LAT  = 2;
    localparam int ECC_LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       d_valid = 1'b0;
    logic [4:0] d_r1sel = '0;
    logic       d_r1re = 1'b0;
    logic [4:0] d_r2sel = '0;
    logic       d_r2re = 1'b0;
    logic [4:0] d_wsel = '0;
    logic       d_regfile_we = 1'b0;
    logic       d_long = 1'b0;
    logic       d_is_control = 1'b0;
    logic       d_ready;
    logic       x_issue;
    logic       flush_fetch;
    logic       wb_valid;
    logic [4:0] wb_sel;
    logic       wb_we;
    logic       busy;

    int checks = 0;
    int failures = 0;

    lc4_issue_ctrl #(.EX_LAT(EX_LAT), .ECC_LAT(ECC_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
        .d_r1sel(d_r1sel), .d_r1re(d_r1re), .d_r2sel(d_r2sel), .d_r2re(d_r2re),
        .d_wsel(d_wsel), .d_regfile_we(d_regfile_we), .d_long(d_long),
        .d_is_control(d_is_control), .d_ready(d_ready), .x_issue(x_issue),
        .flush_fetch(flush_fetch), .wb_valid(wb_valid), .wb_sel(wb_sel),
        .wb_we(wb_we), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: each accepted op lives from its issue cycle until its
    // retire cycle (issue + latency). Everything is derived from that list.
    typedef struct {
        int         it;
        int         rt;
        logic [4:0] sel;
        logic       we;
    } op_t;

    op_t ops[$];
    int  cyc = 0;
    int  last_ctrl = -100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_check();
        bit         e_busy, e_raw, e_waw, e_port, e_flush, e_ready, e_wbv;
        logic [4:0] e_wbs;
        logic       e_wbw;
        int         lat;
        for (int i = ops.size() - 1; i >= 0; i--) begin
            if (ops[i].rt < cyc) ops.delete(i);
        end
        lat = d_long ? ECC_LAT : EX_LAT;
        e_busy = (ops.size() != 0);
        e_raw = 0; e_waw = 0; e_port = 0; e_wbv = 0; e_wbs = '0; e_wbw = 1'b0;
        foreach (ops[i]) begin
            if (ops[i].we && d_r1re && ops[i].sel == d_r1sel) e_raw = 1;
            if (ops[i].we && d_r2re && ops[i].sel == d_r2sel) e_raw = 1;
            if (ops[i].we && d_regfile_we && ops[i].sel == d_wsel) e_waw = 1;
            if (ops[i].rt == cyc + lat) e_port = 1;
            if (ops[i].rt == cyc) begin
                e_wbv = 1; e_wbs = ops[i].sel; e_wbw = ops[i].we;
            end
        end
        e_flush = (last_ctrl == cyc - 1);
        e_ready = d_valid && !e_raw && !e_waw && !e_port && !(d_is_control && e_busy) && !e_flush;
        chk("d_ready", d_ready, e_ready);
        chk("x_issue", x_issue, e_ready);
        chk("flush_fetch", flush_fetch, e_flush);
        chk("busy", busy, e_busy);
        chk("wb_valid", wb_valid, e_wbv);
        chk("wb_sel", wb_sel, e_wbs);
        chk("wb_we", wb_we, e_wbw);
        if (e_ready) begin
            ops.push_back('{it: cyc, rt: cyc + lat, sel: d_wsel, we: d_regfile_we});
            if (d_is_control) last_ctrl = cyc;
        end
    endtask

    task automatic tick(input bit v, input logic [4:0] r1, input bit r1re,
                        input logic [4:0] r2, input bit r2re, input logic [4:0] w,
                        input bit we, input bit lng, input bit ctl);
        @(posedge clk);
        cyc++;
        #1;
        d_valid = v; d_r1sel = r1; d_r1re = r1re; d_r2sel = r2; d_r2re = r2re;
        d_wsel = w; d_regfile_we = we; d_long = lng; d_is_control = ctl;
        @(negedge clk);
        model_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_d_ready"}, d_ready, 0);
        chk({tag, "_x_issue"}, x_issue, 0);
        chk({tag, "_flush"}, flush_fetch, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_sel"}, wb_sel, 0);
        chk({tag, "_wb_we"}, wb_we, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        cyc++;
        #2;
        d_valid = 1'b1; d_regfile_we = 1'b1; d_wsel = 5'd3; d_long = 1'b0; d_is_control = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        d_valid = 1'b0;
        ops.delete();
        last_ctrl = -100;
    endtask

    initial begin
        // Power-on reset with a valid request present.
        d_valid = 1'b1;
        #3;
        check_reset_outputs("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d_valid = 1'b0;

        // Back-to-back independent short ops r1..r4.
        for (int i = 1; i <= 4; i++) begin
            tick(1, 0, 0, 0, 0, 5'(i), 1, 0, 0);
            chk("b2b_issue", x_issue, 1);
        end
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("b2b_wb_sel_t4", wb_sel, 3);
        idle(3);

        // RAW on r3: SUB offered from t=1, issues at t=3.
        tick(1, 0, 0, 0, 0, 5'd3, 1, 0, 0);
        tick(1, 5'd3, 1, 5'd1, 1, 5'd4, 1, 0, 0);
        chk("raw_t1_ready", d_ready, 0);
        tick(1, 5'd3, 1, 5'd1, 1, 5'd4, 1, 0, 0);
        chk("raw_t2_ready", d_ready, 0);
        tick(1, 5'd3, 1, 5'd1, 1, 5'd4, 1, 0, 0);
        chk("raw_t3_issue", x_issue, 1);
        idle(4);

        // Long CHKL (no write) then short ADD r5: port conflict at t=2.
        tick(1, 5'd2, 1, 0, 0, 5'd0, 0, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 5'd5, 1, 0, 0);
        chk("port_t2_ready", d_ready, 0);
        tick(1, 0, 0, 0, 0, 5'd5, 1, 0, 0);
        chk("port_t3_issue", x_issue, 1);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("port_t4_wb_we", {wb_valid, wb_we}, 2'b10);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("port_t5_wb", {wb_valid, wb_sel}, {1'b1, 5'd5});
        idle(2);

        // WAW on r7.
        tick(1, 0, 0, 0, 0, 5'd7, 1, 0, 0);
        for (int i = 1; i <= 3; i++) tick(1, 0, 0, 0, 0, 5'd7, 1, 0, 0);
        chk("waw_t3_issue", x_issue, 1);
        idle(3);

        // JSR drains behind a short op, then a one-cycle flush.
        tick(1, 0, 0, 0, 0, 5'd7, 1, 0, 0);
        for (int i = 1; i <= 3; i++) tick(1, 0, 0, 0, 0, 5'd7, 1, 0, 1);
        chk("jsr_t3_issue", x_issue, 1);
        tick(1, 0, 0, 0, 0, 5'd9, 1, 0, 0);
        chk("jsr_t4_flush", flush_fetch, 1);
        chk("jsr_t4_ready", d_ready, 0);
        tick(1, 0, 0, 0, 0, 5'd9, 1, 0, 0);
        chk("jsr_t5_flush", flush_fetch, 0);
        chk("jsr_t5_wb", {wb_valid, wb_sel}, {1'b1, 5'd7});
        idle(3);

        // Reset while a long op is in flight.
        tick(1, 0, 0, 0, 0, 5'd12, 1, 1, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        pulse_reset();
        tick(1, 5'd12, 1, 0, 0, 5'd12, 1, 0, 0);
        chk("post_reset_pending_clear", x_issue, 1);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_reset_no_stale_wb", wb_valid, 0);
        idle(3);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                pulse_reset();
            end else begin
                tick($urandom_range(0, 9) < 8,
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                     5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            end
        end
        idle(ECC_LAT + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
